mem_stage: RTL
==============

# mem_stage

Memory stage of the five-stage CPU, directly downstream of the execute stage. It consumes the EX/MEM pipeline register (ALU result, store data, destination, DMem/bus controls), drives the synchronous data memory and the accelerator register bus, and registers the MEM/WB result. Bus accesses run through a request/acknowledge state machine that stalls the upstream pipeline until the accelerator responds. `oWbData` also feeds back to execute as the forwarding source `iWriteBackData`.

## Interface
- `BUS_TIMEOUT`, default 255: cycles in REQ before a bus access is aborted (used only with `MEM_BUS_TIMEOUT_EN`; range 1–255).
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  reset; synchronous, active-high
- `iAluOut`  in  16  ALU result; DMem address or writeback value
- `iData2`  in  16  store data / bus write data
- `iAlutoReg`, `iMemtoReg`, `iBustoReg`  in  1 each  writeback source select
- `iDest`  in  4  destination register
- `iBusAddr`  in  3  accelerator register index
- `iMemRead`, `iMemWrite`, `iBusWrite`, `iHalt`  in  1 each  controls from EX/MEM
- `oMemAddr`  out  16  DMem address (= `iAluOut`)
- `oMemWdata`  out  16  DMem write data (= `iData2`)
- `oMemWe`, `oMemRe`  out  1 each  DMem strobes
- `iMemRdata`  in  16  DMem read data, valid one cycle after `oMemRe`
- `oBusReq`, `oBusWe`  out  1 each  bus request / write qualifier
- `oBusAddr`  out  3;  `oBusWdata`  out  16  bus address / data
- `iBusAck`  in  1;  `iBusRdata`  in  16  bus acknowledge / read data (valid with ack)
- `oStall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- `oWbData`  out  16;  `oWriteEn`  out  1;  `oDest`  out  4  to writeback / register file
- `oHalt`  out  1  registered halt
- `oBusErr`  out  1  sticky bus timeout flag

## Operation
- Bus op = `iBusWrite | iBustoReg`. FSM states IDLE, REQ.
- IDLE, no bus op: `oMemWe = iMemWrite`, `oMemRe = iMemRead` combinationally; no stall.
- IDLE, bus op: `oStall = 1`, next state REQ; MEM/WB loads a bubble (`oWriteEn` 0).
- REQ: `oBusReq = 1`, `oBusWe = iBusWrite`, `oBusAddr`/`oBusWdata` from held inputs. `!iBusAck`: `oStall = 1`, bubble. `iBusAck`: `oStall = 0`, MEM/WB captures `iBusRdata` if `iBustoReg`, next state IDLE.
- DMem writes are suppressed whenever a bus op is present; `iBusWrite` together with `iBustoReg` is treated as a write (no writeback).
- MEM/WB register: `oDest`, `oHalt`, `oWriteEn = iAlutoReg|iMemtoReg|iBustoReg` (forced to 0 on bubble), value register (`iAluOut` or bus data), and a select bit `selMem`.
- `oWbData = selMem ? iMemRdata : value register` (combinational mux; DMem read latency absorbed, so loads never stall).
- `oHalt` is loaded from `iHalt` only when `oStall` is low.
- Reset: state IDLE, timeout counter 0; `oWbData`, `oWriteEn`, `oDest`, `oHalt`, `oBusErr`, `oBusReq`, `oStall`, and `selMem` are all 0. A reset during REQ drops `oBusReq` on that edge, and a late `iBusAck` is ignored in IDLE.

## Timing
- ALU/load result: visible on `oWbData` one cycle after it appears on EX/MEM.
- Bus access whose ack arrives in the k-th REQ cycle (k ≥ 1): `oStall` is high for exactly k cycles (the IDLE detect cycle plus k−1 REQ cycles), and the result appears the cycle after ack.
- `oBusReq` is driven only from the registered state and is never asserted in the detect cycle.
- Back-to-back bus ops: the second op enters IDLE detect on the cycle after the first ack, so `oBusReq` drops for one cycle between them.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined: an 8-bit counter clears on entering REQ and increments each REQ cycle without ack. When it reaches `BUS_TIMEOUT`, the access completes as if acked: `oBusReq` drops, read data is 16'hFFFF, and `oBusErr` is set and held until `rst`.
- Not defined: REQ waits indefinitely, there is no counter, and `oBusErr` is tied to 0.

## Structure
- `cpu_pkg` holds the `bus_state_t` enum (IDLE, REQ), `BUS_ERR_DATA = 16'hFFFF`, and the data/register/bus address widths.
- Sub-module `mem_bus_ctrl` contains the FSM, stall generation and timeout counter. `mem_stage` holds the DMem strobes, the MEM/WB register and the writeback mux.

## Test plan
- `iAluOut = 16'h1234`, `iAlutoReg = 1`, `iDest = 3` → next cycle `oWbData = 16'h1234`, `oWriteEn = 1`, `oDest = 3`, no stall.
- Store 16'hBEEF to address 16'h0040, then load 16'h0040 → `oMemWe` is high for exactly one cycle, and `oWbData = 16'hBEEF` the cycle after the load.
- Bus read at `iBusAddr = 5`, ack with `iBusRdata = 16'h00A5` in the 3rd REQ cycle → `oStall` high for 3 cycles, then `oWbData = 16'h00A5`, `oWriteEn = 1`.
- Bus write with `iData2 = 16'h0F0F`, ack in the 1st REQ cycle → `oBusWe = 1`, `oBusWdata = 16'h0F0F`, `oStall` high for exactly 1 cycle, `oWriteEn = 0`.
- `MEM_BUS_TIMEOUT_EN`, `BUS_TIMEOUT = 4`, no ack → `oBusReq` high 4 cycles, then `oWbData = 16'hFFFF`, `oBusErr = 1` held until `rst`.
- Assert `rst` in the 2nd REQ cycle → the next cycle has all outputs 0 and `oBusReq = 0`; a following bus op completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and bus FSM state type for the CPU memory stage
package cpu_pkg;
   localparam int DATA_W     = 16;
   localparam int REG_W      = 4;
   localparam int BUS_ADDR_W = 3;

   localparam logic [DATA_W-1:0] BUS_ERR_DATA = 16'hFFFF;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } bus_state_t;
endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - accelerator register bus between the memory stage (master) and accelerator (slave)
interface mem_stage_if;
   import cpu_pkg::*;

   logic                  busReq;
   logic                  busWe;
   logic [BUS_ADDR_W-1:0] busAddr;
   logic [DATA_W-1:0]     busWdata;
   logic                  busAck;
   logic [DATA_W-1:0]     busRdata;

   modport master (
      output busReq, busWe, busAddr, busWdata,
      input  busAck, busRdata
   );

   modport slave (
      input  busReq, busWe, busAddr, busWdata,
      output busAck, busRdata
   );
endinterface

// File: rtl/mem_stage_bus_ctrl.sv
// rtl/mem_stage_bus_ctrl.sv - bus request/ack FSM, pipeline stall and optional timeout (MEM_BUS_TIMEOUT_EN)
module mem_bus_ctrl
   import cpu_pkg::*;
#(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  busOp,
   input  logic                  busWrite,
   input  logic [BUS_ADDR_W-1:0] busAddr,
   input  logic [DATA_W-1:0]     busWdata,
   mem_stage_if.master           bus,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_W-1:0]     doneData,
   output logic                  busErr
);
   bus_state_t state, stateNext;
   logic       timeout;

   if (BUS_TIMEOUT < 1 || BUS_TIMEOUT > 255) begin : gBadTimeout
      $error("mem_bus_ctrl: BUS_TIMEOUT must be in 1..255");
   end

`ifdef MEM_BUS_TIMEOUT_EN
   logic [7:0] count;
   logic       errFlag;

   // count holds the number of unacked REQ cycles already spent
   assign timeout = (state == REQ) && !bus.busAck && (count == 8'(BUS_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         errFlag <= 1'b0;
      end else begin
         if (state != REQ)
            count <= '0;
         else if (!bus.busAck)
            count <= count + 8'd1;
         if (timeout)
            errFlag <= 1'b1;
      end
   end

   assign busErr = errFlag;
`else
   assign timeout = 1'b0;
   assign busErr  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext    = state;
      stall        = 1'b0;
      done         = 1'b0;
      doneData     = bus.busRdata;
      bus.busReq   = 1'b0;
      bus.busWe    = 1'b0;
      bus.busAddr  = busAddr;
      bus.busWdata = busWdata;
      case (state)
         IDLE: begin
            if (busOp) begin
               stall     = 1'b1;
               stateNext = REQ;
            end
         end
         REQ: begin
            bus.busReq = 1'b1;
            bus.busWe  = busWrite;
            if (bus.busAck) begin
               done      = 1'b1;
               stateNext = IDLE;
            end else if (timeout) begin
               done      = 1'b1;
               doneData  = BUS_ERR_DATA;
               stateNext = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - CPU memory stage: DMem strobes, accelerator bus access, MEM/WB register
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     iAluOut,
   input  logic [DATA_W-1:0]     iData2,
   input  logic                  iAlutoReg,
   input  logic                  iMemtoReg,
   input  logic                  iBustoReg,
   input  logic [REG_W-1:0]      iDest,
   input  logic [BUS_ADDR_W-1:0] iBusAddr,
   input  logic                  iMemRead,
   input  logic                  iMemWrite,
   input  logic                  iBusWrite,
   input  logic                  iHalt,
   output logic [DATA_W-1:0]     oMemAddr,
   output logic [DATA_W-1:0]     oMemWdata,
   output logic                  oMemWe,
   output logic                  oMemRe,
   input  logic [DATA_W-1:0]     iMemRdata,
   mem_stage_if.master           bus,
   output logic                  oStall,
   output logic [DATA_W-1:0]     oWbData,
   output logic                  oWriteEn,
   output logic [REG_W-1:0]      oDest,
   output logic                  oHalt,
   output logic                  oBusErr
);
   logic              busOp;
   logic              done;
   logic [DATA_W-1:0] doneData;
   logic [DATA_W-1:0] wbValue;
   logic              selMem;

   assign busOp     = iBusWrite | iBustoReg;
   assign oMemAddr  = iAluOut;
   assign oMemWdata = iData2;
   assign oMemWe    = iMemWrite & ~busOp;
   assign oMemRe    = iMemRead & ~busOp;

   mem_bus_ctrl #(
      .BUS_TIMEOUT (BUS_TIMEOUT)
   ) uBusCtrl (
      .clk      (clk),
      .rst      (rst),
      .busOp    (busOp),
      .busWrite (iBusWrite),
      .busAddr  (iBusAddr),
      .busWdata (iData2),
      .bus      (bus),
      .stall    (oStall),
      .done     (done),
      .doneData (doneData),
      .busErr   (oBusErr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wbValue  <= '0;
         selMem   <= 1'b0;
         oWriteEn <= 1'b0;
         oDest    <= '0;
         oHalt    <= 1'b0;
      end else if (oStall) begin
         oWriteEn <= 1'b0;
         selMem   <= 1'b0;
      end else begin
         oDest <= iDest;
         oHalt <= iHalt;
         if (done) begin
            // a combined write+read bus op behaves as a write
            wbValue  <= doneData;
            selMem   <= 1'b0;
            oWriteEn <= iBustoReg & ~iBusWrite;
         end else begin
            wbValue  <= iAluOut;
            selMem   <= iMemtoReg;
            oWriteEn <= iAlutoReg | iMemtoReg | iBustoReg;
         end
      end
   end

   // DMem data arrives one cycle after the read strobe, so select it late
   assign oWbData = selMem ? iMemRdata : wbValue;
endmodule
